// File: rtl/vedm_energy_converter_pkg.sv
// Shared constants for the energy-converter controller: regulation thresholds,
// datapath widths and the uo_out pin map.
package vedm_energy_converter_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ENERGY_W   = 16;

  localparam logic [7:0] TARGET_DEF    = 8'd128;
  localparam logic [7:0] OV_THRESH_DEF = 8'd200;
  localparam logic [7:0] UV_THRESH_DEF = 8'd64;
  localparam logic [7:0] MAX_DUTY_DEF  = 8'd240;
  localparam logic [7:0] DUTY_INIT_DEF = 8'd128;

  localparam int PWM_BIT    = 0;
  localparam int PG_BIT     = 1;
  localparam int OV_BIT     = 2;
  localparam int UV_BIT     = 3;
  localparam int ENERGY_MSB = 7;
  localparam int ENERGY_LSB = 4;

  localparam int NIB_W = ENERGY_MSB - ENERGY_LSB + 1;

endpackage

// File: rtl/vedm_energy_converter_if.sv
// Tiny Tapeout user pin bundle; the harness drives it as master, the chip top
// consumes it as slave.
interface vedm_energy_converter_if;
  import vedm_energy_converter_pkg::*;

  logic [DATA_W_DEF-1:0] ui_in;
  logic [DATA_W_DEF-1:0] uo_out;
  logic [DATA_W_DEF-1:0] uio_in;
  logic [DATA_W_DEF-1:0] uio_out;
  logic [DATA_W_DEF-1:0] uio_oe;

  modport master (
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );

endinterface

// File: rtl/vedm_pwm_gen.sv
// Free-running 8-bit PWM with a duty register nudged one step per period
// toward the voltage target.
module vedm_pwm_gen
  import vedm_energy_converter_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [DATA_W-1:0] TARGET    = TARGET_DEF,
  parameter logic [DATA_W-1:0] MAX_DUTY  = MAX_DUTY_DEF,
  parameter logic [DATA_W-1:0] DUTY_INIT = DUTY_INIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] avg,
  input  logic              pg,
  output logic              pwm,
  output logic [DATA_W-1:0] duty
);

  logic [DATA_W-1:0] cnt;

  // One saturating step toward TARGET; the loop runs regardless of the flags.
  function automatic logic [DATA_W-1:0] step_duty(input logic [DATA_W-1:0] d,
                                                  input logic [DATA_W-1:0] a);
    logic [DATA_W-1:0] r;
    r = d;
    if (a > TARGET) begin
      r = (d >= MAX_DUTY) ? MAX_DUTY : d + 1'b1;
    end else if (a < TARGET) begin
      r = (d == '0) ? '0 : d - 1'b1;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      duty <= DUTY_INIT;
      pwm  <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (cnt == '1) begin
        duty <= step_duty(duty, avg);
      end
      pwm <= (cnt < duty) & pg;
    end
  end

endmodule

// File: rtl/vedm_energy_converter.sv
// Chip top: 4-tap moving average of the source sample, OV/UV flags, duty-loop
// PWM and a saturating delivered-energy accumulator behind the TT pin set.
module vedm_energy_converter
  import vedm_energy_converter_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [DATA_W-1:0] TARGET    = TARGET_DEF,
  parameter logic [DATA_W-1:0] OV_THRESH = OV_THRESH_DEF,
  parameter logic [DATA_W-1:0] UV_THRESH = UV_THRESH_DEF,
  parameter logic [DATA_W-1:0] MAX_DUTY  = MAX_DUTY_DEF,
  parameter logic [DATA_W-1:0] DUTY_INIT = DUTY_INIT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   vdd,
  input  logic                   gnd,
  vedm_energy_converter_if.slave tt
);

  logic [DATA_W-1:0]   samp_p0, samp_p1, samp_p2, samp_p3;
  logic [DATA_W+1:0]   sum_c;
  logic [DATA_W-1:0]   avg_p1;
  logic                ov_c, uv_c;
  logic                ov_p2, uv_p2, pg_p2;
  logic                pwm;
  logic [DATA_W-1:0]   duty;
  logic [ENERGY_W-1:0] energy_p2;
  logic [NIB_W-1:0]    energy_nib_p3;
  logic [DATA_W-1:0]   uo_c;
  logic                unused_pins;

  function automatic logic [ENERGY_W-1:0] sat_acc(input logic [ENERGY_W-1:0] acc,
                                                  input logic [DATA_W-1:0]   inc);
    logic [ENERGY_W:0] t;
    t = {1'b0, acc} + {{(ENERGY_W + 1 - DATA_W){1'b0}}, inc};
    return t[ENERGY_W] ? '1 : t[ENERGY_W-1:0];
  endfunction

  // Stage p0: sample shift line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_p0 <= '0;
      samp_p1 <= '0;
      samp_p2 <= '0;
      samp_p3 <= '0;
    end else begin
      samp_p0 <= tt.ui_in;
      samp_p1 <= samp_p0;
      samp_p2 <= samp_p1;
      samp_p3 <= samp_p2;
    end
  end

  assign sum_c = {2'b00, samp_p0} + {2'b00, samp_p1}
               + {2'b00, samp_p2} + {2'b00, samp_p3};

  // Stage p1: truncated average
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_p1 <= '0;
    end else begin
      avg_p1 <= sum_c[DATA_W+1:2];
    end
  end

  assign ov_c = (avg_p1 >= OV_THRESH);
  assign uv_c = (avg_p1 <  UV_THRESH);

  // Stage p2: voltage flags and energy accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_p2     <= 1'b0;
      uv_p2     <= 1'b0;
      pg_p2     <= 1'b0;
      energy_p2 <= '0;
    end else begin
      ov_p2 <= ov_c;
      uv_p2 <= uv_c;
      pg_p2 <= !ov_c & !uv_c;
      if (pwm) begin
        energy_p2 <= sat_acc(energy_p2, avg_p1);
      end
    end
  end

  vedm_pwm_gen #(
    .DATA_W    (DATA_W),
    .TARGET    (TARGET),
    .MAX_DUTY  (MAX_DUTY),
    .DUTY_INIT (DUTY_INIT)
  ) u_pwm (
    .clk   (clk),
    .rst_n (rst_n),
    .avg   (avg_p1),
    .pg    (pg_p2),
    .pwm   (pwm),
    .duty  (duty)
  );

  // Stage p3: energy nibble for the logging pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      energy_nib_p3 <= '0;
    end else begin
      energy_nib_p3 <= energy_p2[ENERGY_W-1 -: NIB_W];
    end
  end

  always_comb begin
    uo_c                        = '0;
    uo_c[PWM_BIT]               = pwm;
    uo_c[PG_BIT]                = pg_p2;
    uo_c[OV_BIT]                = ov_p2;
    uo_c[UV_BIT]                = uv_p2;
    uo_c[ENERGY_MSB:ENERGY_LSB] = energy_nib_p3;
  end

  assign tt.uo_out  = uo_c;
  assign tt.uio_out = '0;
  assign tt.uio_oe  = '0;

  assign unused_pins = &{1'b0, vdd, gnd, tt.uio_in};

endmodule

// File: tb/tb_vedm_energy_converter.sv
// Directed bench for the energy-converter top: reset, filter latency, flags,
// duty loop saturation and energy saturation with hand-computed expectations.
module tb_vedm_energy_converter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  vedm_energy_converter_if tt();

  vedm_energy_converter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vdd   (1'b1),
    .gnd   (1'b0),
    .tt    (tt.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_apply(input logic [7:0] v);
    @(negedge clk);
    rst_n    = 1'b0;
    tt.ui_in = v;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic measure(output int hi, output int first, output int last, output int de);
    int e0;
    hi = 0;
    first = 0;
    last = 0;
    e0 = int'(dut.energy_p2);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      hi += int'(tt.uo_out[0]);
      if (i == 0)   first = int'(tt.uo_out[0]);
      if (i == 255) last  = int'(tt.uo_out[0]);
    end
    de = int'(dut.energy_p2) - e0;
  endtask

  logic [7:0] avg_exp [6]  = '{8'd0, 8'd37, 8'd75, 8'd112, 8'd150, 8'd150};
  logic [2:0] flag_exp [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b001};

  initial begin
    int hi, first, last, de;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    tt.ui_in  = 8'h96;
    tt.uio_in = 8'h00;

    repeat (3) @(negedge clk);
    check_eq("rst_uo", tt.uo_out, 32'h00);
    check_eq("rst_duty", dut.u_pwm.duty, 32'd128);
    check_eq("rst_energy", dut.energy_p2, 32'd0);
    check_eq("rst_uio", {tt.uio_out, tt.uio_oe}, 32'h0);

    tt.ui_in = 8'h00;
    rst_n    = 1'b1;
    #1;
    check_eq("rel_uo", tt.uo_out, 32'h00);
    run(1);
    check_eq("rel_uv", tt.uo_out, 32'h08);

    // Filter latency and flag lag after a 0 -> 150 step
    run(4);
    tt.ui_in = 8'd150;
    for (int i = 0; i < 6; i++) begin
      run(1);
      check_eq($sformatf("avg_step%0d", i + 1), dut.avg_p1, avg_exp[i]);
      check_eq($sformatf("flags_step%0d", i + 1), tt.uo_out[3:1], flag_exp[i]);
    end

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_uo", tt.uo_out, 32'h00);
    check_eq("async_duty", dut.u_pwm.duty, 32'd128);
    check_eq("async_avg", dut.avg_p1, 32'd0);

    // Nominal 150: first period steps duty to 129
    reset_apply(8'd150);
    run(256);
    check_eq("nom_p0_energy", dut.energy_p2, 32'd18600);
    check_eq("nom_duty1", dut.u_pwm.duty, 32'd129);
    measure(hi, first, last, de);
    check_eq("nom_hi", hi, 32'd129);
    check_eq("nom_first", first, 32'd1);
    check_eq("nom_last", last, 32'd0);
    check_eq("nom_de", de, 32'd19350);
    check_eq("nom_duty2", dut.u_pwm.duty, 32'd130);
    check_eq("nom_flags", tt.uo_out[3:1], 32'b001);
    check_eq("nom_nib", tt.uo_out[7:4], 32'h9);

    // Under-voltage
    reset_apply(8'd45);
    run(256);
    check_eq("uv_duty", dut.u_pwm.duty, 32'd127);
    check_eq("uv_flags", tt.uo_out[3:1], 32'b100);
    measure(hi, first, last, de);
    check_eq("uv_hi", hi, 32'd0);
    check_eq("uv_de", de, 32'd0);
    check_eq("uv_energy", dut.energy_p2, 32'd0);

    // Over-voltage: pwm gated, duty loop still steps
    reset_apply(8'd220);
    run(256);
    check_eq("ov_duty1", dut.u_pwm.duty, 32'd129);
    check_eq("ov_flags", tt.uo_out[3:1], 32'b010);
    measure(hi, first, last, de);
    check_eq("ov_hi", hi, 32'd0);
    check_eq("ov_duty2", dut.u_pwm.duty, 32'd130);

    // Threshold boundaries
    reset_apply(8'd200);
    run(8);
    check_eq("ov_edge200", tt.uo_out[3:1], 32'b010);
    reset_apply(8'd64);
    run(8);
    check_eq("pg_edge64", tt.uo_out[3:1], 32'b001);
    reset_apply(8'd63);
    run(8);
    check_eq("uv_edge63", tt.uo_out[3:1], 32'b100);

    // avg == TARGET holds duty
    reset_apply(8'd128);
    run(3 * 256);
    check_eq("hold_duty", dut.u_pwm.duty, 32'd128);
    measure(hi, first, last, de);
    check_eq("hold_hi", hi, 32'd128);
    check_eq("hold_duty2", dut.u_pwm.duty, 32'd128);

    // Upper duty saturation
    reset_apply(8'd150);
    run(120 * 256);
    check_eq("sat_hi_duty", dut.u_pwm.duty, 32'd240);
    measure(hi, first, last, de);
    check_eq("sat_hi_hi", hi, 32'd240);
    check_eq("sat_hi_duty2", dut.u_pwm.duty, 32'd240);

    // Lower duty saturation
    reset_apply(8'd100);
    run(130 * 256);
    check_eq("sat_lo_duty", dut.u_pwm.duty, 32'd0);
    measure(hi, first, last, de);
    check_eq("sat_lo_hi", hi, 32'd0);
    check_eq("sat_lo_duty2", dut.u_pwm.duty, 32'd0);

    // Energy saturation
    reset_apply(8'd199);
    run(10 * 256);
    check_eq("esat_energy", dut.energy_p2, 32'hFFFF);
    check_eq("esat_nib", tt.uo_out[7:4], 32'hF);
    check_eq("esat_flags", tt.uo_out[3:1], 32'b001);
    run(2 * 256);
    check_eq("esat_energy2", dut.energy_p2, 32'hFFFF);
    check_eq("esat_nib2", tt.uo_out[7:4], 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
